// File: rtl/fluxo_dados_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : fluxo_dados_param                                       |
// | Description: Datapath for the memory game: address/limit counters,   |
// |              move register, synchronous-read memory, move detector   |
// |              and saturating timeout counter.                         |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module fluxo_dados_param #(
  parameter int N       = 4,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 3000,
  parameter int TIMER_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N-1:0]      chaves,
  input  logic              zeraE,
  input  logic              contaE,
  input  logic              zeraL,
  input  logic              contaL,
  input  logic              zeraR,
  input  logic              registraR,
  input  logic              escreveM,
  input  logic              zera_timer,
  input  logic              conta_timer,
  output logic              igual,
  output logic              fimE,
  output logic              fimL,
  output logic              fim_sequencia,
  output logic              fim_timer,
  output logic              jogada_feita,
  output logic              jogada_valida,
  output logic              db_tem_jogada,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [ADDR_W-1:0] db_limite,
  output logic [N-1:0]      db_jogada,
  output logic [N-1:0]      db_memoria
);

  localparam int                 c_depth     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0]  c_addr_max  = '1;
  localparam logic [ADDR_W-1:0]  c_addr_one  = ADDR_W'(1);
  localparam logic [TIMER_W-1:0] c_timer_max = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] c_timer_one = TIMER_W'(1);
  localparam logic [N-1:0]       c_n_one     = N'(1);

  logic [ADDR_W-1:0]  r_endereco;
  logic [ADDR_W-1:0]  r_limite;
  logic [N-1:0]       r_jogada;
  logic [N-1:0]       r_leitura;
  logic [TIMER_W-1:0] r_timer;
  logic               r_tem_ant;
  logic               r_jogada_feita;
  logic [N-1:0]       r_mem [0:c_depth-1];

  logic               w_tem_jogada;
  logic [N-1:0]       w_chaves_m1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_endereco <= '0;
      r_limite   <= '0;
      r_jogada   <= '0;
      r_timer    <= '0;
    end else begin
      if (zeraE)       r_endereco <= '0;
      else if (contaE) r_endereco <= r_endereco + c_addr_one;

      if (zeraL)       r_limite <= '0;
      else if (contaL) r_limite <= r_limite + c_addr_one;

      if (zeraR)          r_jogada <= '0;
      else if (registraR) r_jogada <= chaves;

      // Timer holds at its terminal count rather than wrapping.
      if (zera_timer) r_timer <= '0;
      else if (conta_timer && (r_timer != c_timer_max)) r_timer <= r_timer + c_timer_one;
    end
  end

  // Memory has no reset; a write on an edge where reset is high is dropped.
  always_ff @(posedge clock) begin
    if (escreveM && !reset) r_mem[r_endereco] <= r_jogada;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_leitura <= '0;
    else       r_leitura <= r_mem[r_endereco];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tem_ant      <= 1'b0;
      r_jogada_feita <= 1'b0;
    end else begin
      r_tem_ant      <= w_tem_jogada;
      r_jogada_feita <= w_tem_jogada && !r_tem_ant;
    end
  end

  assign w_tem_jogada = |chaves;
  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign w_chaves_m1  = chaves - c_n_one;

  assign db_tem_jogada = w_tem_jogada;
  assign jogada_valida = w_tem_jogada && ((chaves & w_chaves_m1) == '0);
  assign jogada_feita  = r_jogada_feita;
  assign fimE          = (r_endereco == c_addr_max);
  assign fimL          = (r_limite == c_addr_max);
  assign fim_sequencia = (r_endereco == r_limite);
  assign fim_timer     = (r_timer == c_timer_max);
  assign igual         = (r_leitura == r_jogada);
  assign db_contagem   = r_endereco;
  assign db_limite     = r_limite;
  assign db_jogada     = r_jogada;
  assign db_memoria    = r_leitura;

endmodule
`default_nettype wire

// File: tb/tb_fluxo_dados_param.sv
`default_nettype none
// Directed self-checking bench for fluxo_dados_param: default build plus a
// N=6 / ADDR_W=5 build sharing clock and reset.
module tb_fluxo_dados_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // default-parameter instance
  logic [3:0] chaves = '0;
  logic zeraE = 0, contaE = 0, zeraL = 0, contaL = 0, zeraR = 0, registraR = 0;
  logic escreveM = 0, zera_timer = 0, conta_timer = 0;
  logic igual, fimE, fimL, fim_sequencia, fim_timer, jogada_feita, jogada_valida, db_tem_jogada;
  logic [3:0] db_contagem, db_limite, db_jogada, db_memoria;

  fluxo_dados_param #(.N(4), .ADDR_W(4), .TIMEOUT(3000), .TIMER_W(12)) dut (
    .clock(clk), .reset(rst), .chaves(chaves),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .escreveM(escreveM),
    .zera_timer(zera_timer), .conta_timer(conta_timer),
    .igual(igual), .fimE(fimE), .fimL(fimL), .fim_sequencia(fim_sequencia),
    .fim_timer(fim_timer), .jogada_feita(jogada_feita), .jogada_valida(jogada_valida),
    .db_tem_jogada(db_tem_jogada), .db_contagem(db_contagem), .db_limite(db_limite),
    .db_jogada(db_jogada), .db_memoria(db_memoria)
  );

  // wide instance
  logic [5:0] p_chaves = '0;
  logic p_zeraE = 0, p_contaE = 0, p_registraR = 0, p_escreveM = 0;
  logic p_igual, p_fimE, p_fimL, p_fim_sequencia, p_fim_timer, p_jogada_feita, p_jogada_valida, p_tem;
  logic [4:0] p_contagem, p_limite;
  logic [5:0] p_jogada, p_memoria;

  fluxo_dados_param #(.N(6), .ADDR_W(5), .TIMEOUT(3000), .TIMER_W(12)) dut_p (
    .clock(clk), .reset(rst), .chaves(p_chaves),
    .zeraE(p_zeraE), .contaE(p_contaE), .zeraL(1'b0), .contaL(1'b0),
    .zeraR(1'b0), .registraR(p_registraR), .escreveM(p_escreveM),
    .zera_timer(1'b0), .conta_timer(1'b0),
    .igual(p_igual), .fimE(p_fimE), .fimL(p_fimL), .fim_sequencia(p_fim_sequencia),
    .fim_timer(p_fim_timer), .jogada_feita(p_jogada_feita), .jogada_valida(p_jogada_valida),
    .db_tem_jogada(p_tem), .db_contagem(p_contagem), .db_limite(p_limite),
    .db_jogada(p_jogada), .db_memoria(p_memoria)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    if (db_contagem !== 4'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", db_contagem); end
    if (db_limite !== 4'd0) begin failures++; $display("FAIL reset_limit got=%0d exp=0", db_limite); end
    if (fimE !== 1'b0 || fimL !== 1'b0) begin failures++; $display("FAIL reset_fim got=%b%b exp=00", fimE, fimL); end
    if (fim_sequencia !== 1'b1) begin failures++; $display("FAIL reset_fim_seq got=%b exp=1", fim_sequencia); end
    if (igual !== 1'b1) begin failures++; $display("FAIL reset_igual got=%b exp=1", igual); end
    if (fim_timer !== 1'b0 || jogada_feita !== 1'b0) begin
      failures++; $display("FAIL reset_timer_pulse got=%b%b exp=00", fim_timer, jogada_feita);
    end
    checks += 6;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_readback();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 4'b0001 << i;
      chaves = v; registraR = 1; tick(); registraR = 0; chaves = '0;
      escreveM = 1; tick(); escreveM = 0;
      contaE = 1; tick(); contaE = 0;
    end
    zeraE = 1; tick(); zeraE = 0;
    for (int i = 0; i < 4; i++) begin
      v = 4'b0001 << i;
      tick();
      checks++;
      if (db_memoria !== v) begin failures++; $display("FAIL readback_%0d got=%b exp=%b", i, db_memoria, v); end
      chaves = v; registraR = 1; tick(); registraR = 0; chaves = '0;
      checks++;
      if (igual !== 1'b1) begin failures++; $display("FAIL igual_%0d got=%b exp=1", i, igual); end
      contaE = 1; tick(); contaE = 0;
      checks++;
      if (db_memoria !== v) begin failures++; $display("FAIL latency_%0d got=%b exp=%b", i, db_memoria, v); end
    end
    // same-edge write and read at address 0 returns the old word
    zeraE = 1; tick(); zeraE = 0;
    chaves = 4'b1111; registraR = 1; tick(); registraR = 0; chaves = '0;
    checks++;
    if (igual !== 1'b0) begin failures++; $display("FAIL igual_mismatch got=%b exp=0", igual); end
    escreveM = 1; tick(); escreveM = 0;
    checks++;
    if (db_memoria !== 4'b0001) begin failures++; $display("FAIL write_read_old got=%b exp=0001", db_memoria); end
    tick();
    checks++;
    if (db_memoria !== 4'b1111) begin failures++; $display("FAIL write_read_new got=%b exp=1111", db_memoria); end
  endtask

  task automatic test_wrap();
    zeraE = 1; zeraL = 1; tick(); zeraE = 0; zeraL = 0;
    for (int k = 1; k <= 16; k++) begin
      contaE = 1; tick(); contaE = 0;
      if (k == 14) begin
        checks++;
        if (fimE !== 1'b0) begin failures++; $display("FAIL fimE_early got=%b exp=0", fimE); end
      end
      if (k == 15) begin
        checks++;
        if (fimE !== 1'b1 || db_contagem !== 4'd15) begin
          failures++; $display("FAIL wrap_15 got=%b/%0d exp=1/15", fimE, db_contagem);
        end
      end
      if (k == 16) begin
        checks++;
        if (fimE !== 1'b0 || db_contagem !== 4'd0) begin
          failures++; $display("FAIL wrap_16 got=%b/%0d exp=0/0", fimE, db_contagem);
        end
      end
    end
    contaE = 1; contaL = 1; tick(); tick(); tick(); contaL = 0;
    checks++;
    if (fim_sequencia !== 1'b1 || db_limite !== 4'd3) begin
      failures++; $display("FAIL fim_seq_eq got=%b/%0d exp=1/3", fim_sequencia, db_limite);
    end
    tick(); contaE = 0;
    checks++;
    if (fim_sequencia !== 1'b0) begin failures++; $display("FAIL fim_seq_ne got=%b exp=0", fim_sequencia); end
    zeraE = 1; contaE = 1; tick(); zeraE = 0; contaE = 0;
    checks++;
    if (db_contagem !== 4'd0) begin failures++; $display("FAIL zera_priority got=%0d exp=0", db_contagem); end
    for (int k = 0; k < 12; k++) begin contaL = 1; tick(); end
    contaL = 0;
    checks++;
    if (fimL !== 1'b1 || db_limite !== 4'd15) begin
      failures++; $display("FAIL fimL got=%b/%0d exp=1/15", fimL, db_limite);
    end
    zeraL = 1; contaL = 1; tick(); zeraL = 0; contaL = 0;
    checks++;
    if (db_limite !== 4'd0 || fimL !== 1'b0) begin
      failures++; $display("FAIL zeraL_priority got=%0d/%b exp=0/0", db_limite, fimL);
    end
  endtask

  task automatic test_edge_detect();
    int pulses;
    chaves = '0; tick(); tick();
    chaves = 4'b0100;
    #1;
    checks++;
    if (jogada_valida !== 1'b1 || db_tem_jogada !== 1'b1) begin
      failures++; $display("FAIL onehot_valid got=%b/%b exp=1/1", jogada_valida, db_tem_jogada);
    end
    tick();
    checks++;
    if (jogada_feita !== 1'b1) begin failures++; $display("FAIL pulse_first got=%b exp=1", jogada_feita); end
    pulses = 1;
    for (int k = 0; k < 4; k++) begin tick(); if (jogada_feita === 1'b1) pulses++; end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL pulse_count got=%0d exp=1", pulses); end
    chaves = 4'b0110;
    #1;
    checks++;
    if (jogada_valida !== 1'b0 || db_tem_jogada !== 1'b1) begin
      failures++; $display("FAIL twohot_valid got=%b/%b exp=0/1", jogada_valida, db_tem_jogada);
    end
    tick(); tick();
    checks++;
    if (jogada_feita !== 1'b0) begin failures++; $display("FAIL held_no_pulse got=%b exp=0", jogada_feita); end
    chaves = '0;
    #1;
    checks++;
    if (jogada_valida !== 1'b0 || db_tem_jogada !== 1'b0) begin
      failures++; $display("FAIL none_valid got=%b/%b exp=0/0", jogada_valida, db_tem_jogada);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    zera_timer = 1; tick(); zera_timer = 0;
    conta_timer = 1;
    n = 0;
    while (fim_timer !== 1'b1 && n < 4000) begin tick(); n++; end
    checks++;
    if (n != 2999) begin failures++; $display("FAIL timeout_count got=%0d exp=2999", n); end
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (fim_timer !== 1'b1) begin failures++; $display("FAIL timeout_hold got=%b exp=1", fim_timer); end
    zera_timer = 1; tick(); zera_timer = 0; conta_timer = 0;
    checks++;
    if (fim_timer !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", fim_timer); end
  endtask

  task automatic test_reset_mid();
    zeraE = 1; zeraL = 1; zera_timer = 1; tick(); zeraE = 0; zeraL = 0; zera_timer = 0;
    contaE = 1; contaL = 1; conta_timer = 1;
    for (int k = 0; k < 5; k++) tick();
    contaE = 0; contaL = 0;
    for (int k = 0; k < 95; k++) tick();
    conta_timer = 0;
    checks++;
    if (db_contagem !== 4'd5 || db_limite !== 4'd5) begin
      failures++; $display("FAIL pre_reset got=%0d/%0d exp=5/5", db_contagem, db_limite);
    end
    chaves = 4'b1010; registraR = 1; tick(); registraR = 0; chaves = '0;
    escreveM = 1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (db_contagem !== 4'd0 || db_limite !== 4'd0 || db_jogada !== 4'd0 || db_memoria !== 4'd0) begin
      failures++; $display("FAIL async_reset got=%0d/%0d/%b/%b exp=0/0/0000/0000",
                           db_contagem, db_limite, db_jogada, db_memoria);
    end
    checks++;
    if (fim_sequencia !== 1'b1 || fim_timer !== 1'b0) begin
      failures++; $display("FAIL async_reset_flags got=%b/%b exp=1/0", fim_sequencia, fim_timer);
    end
    tick();
    rst = 1'b0; escreveM = 0;
    tick();
    checks++;
    if (db_memoria !== 4'b1111) begin failures++; $display("FAIL mem_kept_0 got=%b exp=1111", db_memoria); end
    contaE = 1; tick(); contaE = 0; tick();
    checks++;
    if (db_memoria !== 4'b0010) begin failures++; $display("FAIL mem_kept_1 got=%b exp=0010", db_memoria); end
  endtask

  task automatic test_sweep();
    p_zeraE = 1; tick(); p_zeraE = 0;
    for (int k = 1; k <= 32; k++) begin
      p_contaE = 1; tick(); p_contaE = 0;
      if (k == 31) begin
        checks++;
        if (p_fimE !== 1'b1 || p_contagem !== 5'd31) begin
          failures++; $display("FAIL sweep_wrap_31 got=%b/%0d exp=1/31", p_fimE, p_contagem);
        end
      end
    end
    checks++;
    if (p_fimE !== 1'b0 || p_contagem !== 5'd0) begin
      failures++; $display("FAIL sweep_wrap_32 got=%b/%0d exp=0/0", p_fimE, p_contagem);
    end
    p_chaves = 6'b100000;
    #1;
    checks++;
    if (p_jogada_valida !== 1'b1) begin failures++; $display("FAIL sweep_onehot got=%b exp=1", p_jogada_valida); end
    p_registraR = 1; tick(); p_registraR = 0;
    p_escreveM = 1; tick(); p_escreveM = 0;
    tick();
    checks++;
    if (p_memoria !== 6'b100000 || p_igual !== 1'b1) begin
      failures++; $display("FAIL sweep_mem got=%b/%b exp=100000/1", p_memoria, p_igual);
    end
    p_chaves = 6'b010000; p_registraR = 1; tick(); p_registraR = 0;
    checks++;
    if (p_igual !== 1'b0) begin failures++; $display("FAIL sweep_igual_ne got=%b exp=0", p_igual); end
    p_chaves = 6'b100001;
    #1;
    checks++;
    if (p_jogada_valida !== 1'b0) begin failures++; $display("FAIL sweep_twohot got=%b exp=0", p_jogada_valida); end
    p_chaves = '0;
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_wrap();
    test_edge_detect();
    test_timeout();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
